// File: rtl/regfile_scoreboard_if.sv
// Bundle of the writeback, decode-read and issue signals between the pipeline
// and the register file / scoreboard.
interface regfile_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int IW = $clog2(NREG);

  logic            rdvalid_i;
  logic [IW-1:0]   rdnum_i;
  logic [XLEN-1:0] rddata_i;
  logic [IW-1:0]   rs1num_i;
  logic [IW-1:0]   rs2num_i;
  logic            rs1use_i;
  logic            rs2use_i;
  logic            issue_valid_i;
  logic            issue_rdwr_i;
  logic [IW-1:0]   issue_rd_i;
  logic            issue_ready_o;
  logic [XLEN-1:0] r0data_o;
  logic [XLEN-1:0] r1data_o;
  logic [NREG-1:0] pending_o;

  // Pipeline side: drives writeback/decode/issue, observes operands and stall.
  modport master (
    output rdvalid_i, rdnum_i, rddata_i,
    output rs1num_i, rs2num_i, rs1use_i, rs2use_i,
    output issue_valid_i, issue_rdwr_i, issue_rd_i,
    input  issue_ready_o, r0data_o, r1data_o, pending_o
  );

  // Register file side.
  modport slave (
    input  rdvalid_i, rdnum_i, rddata_i,
    input  rs1num_i, rs2num_i, rs1use_i, rs2use_i,
    input  issue_valid_i, issue_rdwr_i, issue_rd_i,
    output issue_ready_o, r0data_o, r1data_o, pending_o
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-through read bypass and a pending-write
// scoreboard that stalls issue on RAW/WAW hazards against outstanding
// writebacks. x0 is hardwired to zero and is never marked pending.
module regfile_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);
  localparam int IW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  logic wr_en;
  logic rs1_haz;
  logic rs2_haz;
  logic waw_haz;
  logic ready;
  logic issue_set;

  // Hazard detection; a register retiring this cycle no longer blocks.
  always_comb begin
    wr_en   = bus.rdvalid_i && (bus.rdnum_i != '0);
    rs1_haz = bus.rs1use_i && (bus.rs1num_i != '0) && pending_q[bus.rs1num_i]
              && !(wr_en && (bus.rdnum_i == bus.rs1num_i));
    rs2_haz = bus.rs2use_i && (bus.rs2num_i != '0) && pending_q[bus.rs2num_i]
              && !(wr_en && (bus.rdnum_i == bus.rs2num_i));
    waw_haz = bus.issue_rdwr_i && (bus.issue_rd_i != '0) && pending_q[bus.issue_rd_i]
              && !(wr_en && (bus.rdnum_i == bus.issue_rd_i));
    ready     = !(rs1_haz || rs2_haz || waw_haz);
    issue_set = bus.issue_valid_i && ready && bus.issue_rdwr_i && (bus.issue_rd_i != '0);
  end

  // Scoreboard next state: retire clears first, then a new issue sets, so a
  // producer issuing on the retiring cycle keeps the bit asserted.
  always_comb begin
    pending_d = pending_q;
    if (wr_en)     pending_d[bus.rdnum_i]    = 1'b0;
    if (issue_set) pending_d[bus.issue_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Register array next state; x0 writes are discarded.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[bus.rdnum_i] = bus.rddata_i;
    regs_d[0] = '0;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  // Operand read with same-cycle writeback bypass.
  always_comb begin
    if (bus.rs1num_i == '0)
      bus.r0data_o = '0;
    else if (wr_en && (bus.rdnum_i == bus.rs1num_i))
      bus.r0data_o = bus.rddata_i;
    else
      bus.r0data_o = regs_q[bus.rs1num_i];

    if (bus.rs2num_i == '0)
      bus.r1data_o = '0;
    else if (wr_en && (bus.rdnum_i == bus.rs2num_i))
      bus.r1data_o = bus.rddata_i;
    else
      bus.r1data_o = regs_q[bus.rs2num_i];
  end

  // Status outputs.
  always_comb begin
    bus.issue_ready_o = ready;
    bus.pending_o     = pending_q;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed, table-driven bench for regfile_scoreboard.
module tb_regfile_scoreboard;
  localparam int XLEN = 32;
  localparam int NREG = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  regfile_scoreboard_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdvalid;
    logic [4:0]  rdnum;
    logic [31:0] rddata;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1use;
    logic        rs2use;
    logic        iv;
    logic        irdwr;
    logic [4:0]  ird;
    logic        exp_ready;
    logic [31:0] exp_r0;
    logic [31:0] exp_r1;
    logic [31:0] exp_pend;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.rdvalid_i     = 1'b0;
    bus.rdnum_i       = '0;
    bus.rddata_i      = '0;
    bus.rs1num_i      = '0;
    bus.rs2num_i      = '0;
    bus.rs1use_i      = 1'b0;
    bus.rs2use_i      = 1'b0;
    bus.issue_valid_i = 1'b0;
    bus.issue_rdwr_i  = 1'b0;
    bus.issue_rd_i    = '0;
  endtask

  // Drive one vector just after a rising edge, compare at the falling edge,
  // then let the next rising edge commit it.
  task automatic apply_vec(input int idx, input vec_t v);
    bus.rdvalid_i     = v.rdvalid;
    bus.rdnum_i       = v.rdnum;
    bus.rddata_i      = v.rddata;
    bus.rs1num_i      = v.rs1;
    bus.rs2num_i      = v.rs2;
    bus.rs1use_i      = v.rs1use;
    bus.rs2use_i      = v.rs2use;
    bus.issue_valid_i = v.iv;
    bus.issue_rdwr_i  = v.irdwr;
    bus.issue_rd_i    = v.ird;
    @(negedge clk);
    check($sformatf("v%0d_ready", idx), {31'b0, bus.issue_ready_o}, {31'b0, v.exp_ready});
    check($sformatf("v%0d_r0", idx), bus.r0data_o, v.exp_r0);
    check($sformatf("v%0d_r1", idx), bus.r1data_o, v.exp_r1);
    check($sformatf("v%0d_pend", idx), bus.pending_o, v.exp_pend);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    //            rdv rdn    rddata        rs1    rs2    u1 u2 iv wr ird    rdy r0            r1            pend
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  1, 1, 1, 0, 5'd0,  1, 32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd6,  1, 1, 1, 0, 5'd0,  1, 32'hDEADBEEF, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  1, 1, 0, 0, 5'd0,  1, 32'hDEADBEEF, 32'h0,        32'h0};
    vecs[3]  = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  1, 0, 1, 1, 5'd0,  1, 32'h0,        32'h0,        32'h0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  1, 1, 0, 0, 5'd0,  1, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  0, 0, 1, 1, 5'd7,  1, 32'h0,        32'h0,        32'h0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  0, 1, 1, 0, 5'd0,  0, 32'h0,        32'h0,        32'h80};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  0, 1, 0, 0, 5'd0,  0, 32'h0,        32'h0,        32'h80};
    vecs[8]  = '{1'b1, 5'd7,  32'h55,       5'd0,  5'd7,  0, 1, 1, 0, 5'd0,  1, 32'h0,        32'h55,       32'h80};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  0, 1, 1, 0, 5'd0,  1, 32'h0,        32'h55,       32'h0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  0, 0, 1, 1, 5'd9,  1, 32'h0,        32'h0,        32'h0};
    vecs[11] = '{1'b1, 5'd9,  32'h99,       5'd9,  5'd0,  1, 0, 1, 1, 5'd9,  1, 32'h99,       32'h0,        32'h200};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  0, 0, 1, 1, 5'd9,  0, 32'h99,       32'h0,        32'h200};
    vecs[13] = '{1'b1, 5'd9,  32'h100,      5'd3,  5'd0,  0, 0, 0, 0, 5'd0,  1, 32'h0,        32'h0,        32'h200};
    vecs[14] = '{1'b1, 5'd10, 32'h1010,     5'd10, 5'd9,  1, 1, 0, 0, 5'd0,  1, 32'h1010,     32'h100,      32'h0};
    vecs[15] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd10, 5'd31, 1, 1, 0, 0, 5'd0,  1, 32'h1010,     32'hFFFFFFFF, 32'h0};
    vecs[16] = '{1'b1, 5'd4,  32'hA5,       5'd4,  5'd31, 0, 0, 1, 1, 5'd3,  1, 32'hA5,       32'hFFFFFFFF, 32'h0};
    vecs[17] = '{1'b0, 5'd0,  32'h0,        5'd4,  5'd3,  0, 0, 1, 1, 5'd4,  1, 32'hA5,       32'h0,        32'h8};

    idle_inputs();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    #1;

    // Out of reset: every register reads zero, nothing pending.
    for (int i = 1; i < NREG; i++) begin
      bus.rs1num_i = 5'(i);
      bus.rs2num_i = 5'(NREG - i);
      #1;
      check($sformatf("rst_r0_x%0d", i), bus.r0data_o, 32'h0);
      check($sformatf("rst_r1_x%0d", NREG - i), bus.r1data_o, 32'h0);
    end
    check("rst_pend", bus.pending_o, 32'h0);

    @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++) apply_vec(i, vecs[i]);

    // x3 and x4 pending, x4 holds 0xA5; reset between edges clears at once.
    idle_inputs();
    bus.rs1num_i = 5'd4;
    bus.rs2num_i = 5'd31;
    bus.rs1use_i = 1'b1;
    #1;
    check("pre_rst_pend", bus.pending_o, 32'h18);
    check("pre_rst_ready", {31'b0, bus.issue_ready_o}, 32'h0);
    check("pre_rst_r0", bus.r0data_o, 32'hA5);
    rst = 1'b1;
    #1;
    check("async_rst_pend", bus.pending_o, 32'h0);
    check("async_rst_r0", bus.r0data_o, 32'h0);
    check("async_rst_r1", bus.r1data_o, 32'h0);
    check("async_rst_ready", {31'b0, bus.issue_ready_o}, 32'h1);
    #1;
    rst = 1'b0;

    // After reset, an issue followed by a dependent rs1 read stalls next cycle.
    @(posedge clk);
    #1;
    bus.issue_valid_i = 1'b1;
    bus.issue_rdwr_i  = 1'b1;
    bus.issue_rd_i    = 5'd12;
    bus.rs1use_i      = 1'b0;
    @(posedge clk);
    #1;
    bus.issue_rdwr_i = 1'b0;
    bus.rs1num_i     = 5'd12;
    bus.rs1use_i     = 1'b1;
    #1;
    check("post_rst_pend", bus.pending_o, 32'h1000);
    check("post_rst_raw_ready", {31'b0, bus.issue_ready_o}, 32'h0);
    check("post_rst_r0", bus.r0data_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
